ula_seq: RTL and testbench

- Initiator side of the ULA datapath interface: accepts operation commands over a valid/ready handshake and drives a 32-bit ULA's operand/function inputs (A, B, func).
- Holds those inputs stable for a programmable settle window to cover the ripple-carry path, captures R and pinV, and returns them over a valid/ready response channel.
- Sits between the control/decode logic and the combinational ULA.
- Also keeps a saturating count of overflowing results.

---
 rtl/ula_seq.sv | 152 +++++++++++++++
 tb/tb_ula_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: command/response sequencer in front of a combinational 32-bit ULA.
// Registers operands and function, holds them for SETTLE_CYCLES edges so the
// ripple-carry path can settle, then captures R/pinV into a response.
// A saturating counter tracks how many captured results overflowed.
//
// Optional build macro ULA_SEQ_ACC_EN adds the cmd_acc input and a result
// accumulator that can replace operand A on accept.
module ula_seq #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_func,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_func,
  input  logic [31:0]      alu_r,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_r,
  output logic             rsp_v,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_count
`ifdef ULA_SEQ_ACC_EN
  ,
  input  logic             cmd_acc
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic                accept;
  logic [DATA_W-1:0]   load_a;
  logic                ovf_sat;

`ifdef ULA_SEQ_ACC_EN
  logic [DATA_W-1:0]   acc;
`endif

  // Handshake readiness: free in IDLE, or in RESP when the response drains this cycle
  always_comb begin
    cmd_ready = 1'b0;
    if (state == IDLE) begin
      cmd_ready = 1'b1;
    end else if (state == RESP) begin
      cmd_ready = rsp_ready;
    end
  end

  assign accept  = cmd_valid & cmd_ready;
  assign ovf_sat = (ovf_count == {CNT_W{1'b1}});

  // Operand A source: the command operand, or the last captured result when chaining
  always_comb begin
    load_a = cmd_a;
`ifdef ULA_SEQ_ACC_EN
    if (cmd_acc) begin
      load_a = acc;
    end
`endif
  end

  // Sequencer state, ULA operand registers, response capture and overflow count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= '0;
      rsp_r     <= '0;
      rsp_v     <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      ovf_count <= '0;
`ifdef ULA_SEQ_ACC_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= load_a;
            alu_b    <= cmd_b;
            alu_func <= FUNC_W'(cmd_func);
            cnt      <= WAIT_W'(SETTLE_CYCLES - 1);
            state    <= SETTLE;
            busy     <= 1'b1;
          end
        end

        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
          end else begin
            // Inputs have been stable for the full window; sample the ULA
            rsp_r     <= alu_r;
            rsp_v     <= alu_v;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef ULA_SEQ_ACC_EN
            acc       <= alu_r;
`endif
            if (alu_v && !ovf_sat) begin
              ovf_count <= ovf_count + CNT_W'(1);
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (accept) begin
              // Back-to-back: response drains and next command loads on the same edge
              alu_a    <= load_a;
              alu_b    <= cmd_b;
              alu_func <= FUNC_W'(cmd_func);
              cnt      <= WAIT_W'(SETTLE_CYCLES - 1);
              state    <= SETTLE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed bench for ula_seq with an adder stub standing in for the ULA.
module tb_ula_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_func;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_func;
  logic [31:0] alu_r;
  logic        alu_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_r;
  logic        rsp_v;
  logic        busy;
  logic [3:0]  ovf_count;
`ifdef ULA_SEQ_ACC_EN
  logic        cmd_acc;
`endif

  int checks;
  int failures;

  ula_seq #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_func  (cmd_func),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_r     (alu_r),
    .alu_v     (alu_v),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_v     (rsp_v),
    .busy      (busy),
    .ovf_count (ovf_count)
`ifdef ULA_SEQ_ACC_EN
    ,
    .cmd_acc   (cmd_acc)
`endif
  );

  // ULA stub: wrapping add, signed overflow flag
  assign alu_r = alu_a + alu_b;
  assign alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_cnt;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_func  = 3'b111;
    cmd_a     = 32'h55;
    cmd_b     = 32'h66;
    rsp_ready = 1'b0;
`ifdef ULA_SEQ_ACC_EN
    cmd_acc   = 1'b0;
`endif

    // 1: reset with a pending command
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_ovf", 32'(ovf_count), 32'd0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // 2: single op, latency and pass-through
    cmd_valid = 1'b1; cmd_a = 32'd5; cmd_b = 32'd7; cmd_func = 3'b010;
    tick();
    cmd_valid = 1'b0;
    chk("acc_alu_a", alu_a, 32'd5);
    chk("acc_alu_func", 32'(alu_func), 32'h2);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("settle1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("settle1_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_rsp_r", rsp_r, 32'd12);
    chk("lat_rsp_v", 32'(rsp_v), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // 3: overflow counting and saturation at 15
    for (int i = 0; i < 17; i++) begin
      cmd_valid = 1'b1; cmd_a = 32'h7FFF_FFFF; cmd_b = 32'd1; cmd_func = 3'b000;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      exp_cnt = (i + 1 > 15) ? 32'd15 : 32'(i + 1);
      chk("ovf_rsp_r", rsp_r, 32'h8000_0000);
      chk("ovf_rsp_v", 32'(rsp_v), 32'd1);
      chk("ovf_count", 32'(ovf_count), exp_cnt);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end

    // 4: backpressure then back-to-back handshake
    cmd_valid = 1'b1; cmd_a = 32'd3; cmd_b = 32'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_r", rsp_r, 32'd7);
      chk("hold_rsp_v", 32'(rsp_v), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_a = 32'd1; cmd_b = 32'd1;
    #1;
    chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_alu_a", alu_a, 32'd1);
    tick();
    chk("b2b_settle_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("b2b_rsp_valid2", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp_r", rsp_r, 32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 5: reset in the middle of SETTLE discards the op
    cmd_valid = 1'b1; cmd_a = 32'h7FFF_FFFF; cmd_b = 32'd1;
    tick();
    cmd_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_ovf", 32'(ovf_count), 32'd0);
    tick();
    tick();
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ovf2", 32'(ovf_count), 32'd0);

    // 6: chained op, accumulator feeds A only when the feature is built in
    cmd_valid = 1'b1; cmd_a = 32'd10; cmd_b = 32'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("acc1_rsp_r", rsp_r, 32'd15);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_a = 32'd999; cmd_b = 32'd3;
`ifdef ULA_SEQ_ACC_EN
    cmd_acc = 1'b1;
`endif
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
`ifdef ULA_SEQ_ACC_EN
    cmd_acc = 1'b0;
    chk("acc2_alu_a", alu_a, 32'd15);
`else
    chk("acc2_alu_a", alu_a, 32'd999);
`endif
    chk("acc2_alu_b", alu_b, 32'd3);
    tick();
    tick();
    chk("acc2_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef ULA_SEQ_ACC_EN
    chk("acc2_rsp_r", rsp_r, 32'd18);
`else
    chk("acc2_rsp_r", rsp_r, 32'd1002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
